// File: rtl/i2c_slave_target.sv
// Oversampled I2C target: synchronizes SCL/SDA into clk, decodes START/STOP,
// matches a 7-bit address, ACKs writes and serves read bytes from rd_data.
module i2c_slave_target #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h55,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda_i,
    output logic       i2c_sda_o,
    input  logic [7:0] rd_data,
    output logic       rd_req,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    output logic       addr_match,
    output logic       busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_WRITE     = 3'd3;
    localparam logic [2:0] S_WR_ACK    = 3'd4;
    localparam logic [2:0] S_READ      = 3'd5;
    localparam logic [2:0] S_RD_ACK    = 3'd6;
    localparam logic [2:0] S_WAIT_STOP = 3'd7;

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    logic       scl_s;
    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;

    logic [2:0] state_q,      state_d;
    logic [2:0] bit_cnt_q,    bit_cnt_d;
    logic [6:0] shift_q,      shift_d;
    logic       rw_q,         rw_d;
    logic       ack_phase_q,  ack_phase_d;
    logic       sda_o_q,      sda_o_d;
    logic       rd_req_q,     rd_req_d;
    logic [7:0] wr_data_q,    wr_data_d;
    logic       wr_valid_q,   wr_valid_d;
    logic       addr_match_q, addr_match_d;
    logic       busy_q,       busy_d;

    // Idle bus is high, so synchronizers reset to 1 to avoid phantom edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i2c_scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i2c_sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rw_d         = rw_q;
        ack_phase_d  = ack_phase_q;
        sda_o_d      = sda_o_q;
        rd_req_d     = 1'b0;
        wr_data_d    = wr_data_q;
        wr_valid_d   = 1'b0;
        addr_match_d = addr_match_q;
        busy_d       = busy_q;

        if (stop_det) begin
            state_d      = S_IDLE;
            sda_o_d      = 1'b1;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
            bit_cnt_d    = 3'd0;
            ack_phase_d  = 1'b0;
        end else if (start_det) begin
            state_d      = S_ADDR;
            sda_o_d      = 1'b1;
            busy_d       = 1'b1;
            addr_match_d = 1'b0;
            bit_cnt_d    = 3'd0;
            ack_phase_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_WAIT_STOP: begin
                    sda_o_d = 1'b1;
                end

                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        // On the 8th rise shift_q holds the 7 address bits and sda_s is R/W.
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_q == SLAVE_ADDR) begin
                                state_d     = S_ADDR_ACK;
                                rw_d        = sda_s;
                                rd_req_d    = sda_s;
                                ack_phase_d = 1'b0;
                            end else begin
                                state_d = S_WAIT_STOP;
                                sda_o_d = 1'b1;
                            end
                        end
                    end
                end

                S_ADDR_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_o_d     = 1'b0;
                            ack_phase_d = 1'b1;
                            if (state_q == S_ADDR_ACK) begin
                                addr_match_d = 1'b1;
                            end
                        end else begin
                            ack_phase_d = 1'b0;
                            bit_cnt_d   = 3'd0;
                            if (state_q == S_WR_ACK || !rw_q) begin
                                sda_o_d = 1'b1;
                                state_d = S_WRITE;
                            end else begin
                                shift_d = rd_data[6:0];
                                sda_o_d = rd_data[7];
                                state_d = S_READ;
                            end
                        end
                    end
                end

                S_WRITE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            wr_data_d   = {shift_q, sda_s};
                            wr_valid_d  = 1'b1;
                            state_d     = S_WR_ACK;
                            ack_phase_d = 1'b0;
                        end
                    end
                end

                S_READ: begin
                    // Counts falls: seven more data bits, then the release for the ACK clock.
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            sda_o_d     = 1'b1;
                            state_d     = S_RD_ACK;
                            ack_phase_d = 1'b0;
                        end else begin
                            sda_o_d = shift_q[6];
                            shift_d = {shift_q[5:0], 1'b0};
                        end
                    end
                end

                S_RD_ACK: begin
                    if (scl_rise && !ack_phase_q) begin
                        if (!sda_s) begin
                            rd_req_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end else begin
                            state_d      = S_WAIT_STOP;
                            addr_match_d = 1'b0;
                        end
                    end else if (scl_fall && ack_phase_q) begin
                        shift_d     = rd_data[6:0];
                        sda_o_d     = rd_data[7];
                        bit_cnt_d   = 3'd0;
                        ack_phase_d = 1'b0;
                        state_d     = S_READ;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    sda_o_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            rw_q         <= 1'b0;
            ack_phase_q  <= 1'b0;
            sda_o_q      <= 1'b1;
            rd_req_q     <= 1'b0;
            wr_data_q    <= 8'h00;
            wr_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rw_q         <= rw_d;
            ack_phase_q  <= ack_phase_d;
            sda_o_q      <= sda_o_d;
            rd_req_q     <= rd_req_d;
            wr_data_q    <= wr_data_d;
            wr_valid_q   <= wr_valid_d;
            addr_match_q <= addr_match_d;
            busy_q       <= busy_d;
        end
    end

    assign i2c_sda_o  = sda_o_q;
    assign rd_req     = rd_req_q;
    assign wr_data    = wr_data_q;
    assign wr_valid   = wr_valid_q;
    assign addr_match = addr_match_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: a bit-banged master on a wired-AND SDA line,
// with queues of expected write bytes and expected read bits.
module tb_i2c_slave_target;

    localparam int Q = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] rd_data = 8'h00;
    logic       i2c_sda_o;
    logic       rd_req;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       addr_match;
    logic       busy;
    logic       sda_bus;

    int checks = 0;
    int passes = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    logic [7:0] exp_wr[$];
    logic [7:0] rd_src[$];
    logic       exp_bit[$];

    assign sda_bus = m_sda & i2c_sda_o;

    i2c_slave_target #(.SLAVE_ADDR(7'h55), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .i2c_scl    (m_scl),
        .i2c_sda_i  (sda_bus),
        .i2c_sda_o  (i2c_sda_o),
        .rd_data    (rd_data),
        .rd_req     (rd_req),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .addr_match (addr_match),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard side: each wr_valid pops an expected byte; rd_req hands out the next source byte.
    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            checks++;
            if (exp_wr.size() == 0) begin
                $display("FAIL wr_unexpected: got wr_data=%02h, required no write", wr_data);
            end else begin
                logic [7:0] e;
                e = exp_wr.pop_front();
                if (wr_data !== e) $display("FAIL wr_data: got %02h, required %02h", wr_data, e);
                else passes++;
            end
        end
        if (rd_req) begin
            rd_cnt++;
            if (rd_src.size() > 0) rd_data = rd_src.pop_front();
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        m_sda = b;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q / 2);
        s = sda_bus;
        wait_clk(Q / 2);
        m_scl = 1'b0;
        wait_clk(4);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        m_sda = 1'b0;
        wait_clk(Q);
        m_scl = 1'b0;
        wait_clk(4);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        m_sda = 1'b1;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
        $display("write byte %02h ack=%0b", b, ack);
    endtask

    task automatic push_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_bit.push_back(b[i]);
    endtask

    task automatic read_byte(input logic mack);
        logic s;
        logic e;
        logic [7:0] got;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            got[i] = s;
            checks++;
            if (exp_bit.size() == 0) begin
                $display("FAIL rd_bit_unexpected: got %0b, required no bit queued", s);
            end else begin
                e = exp_bit.pop_front();
                if (s !== e) $display("FAIL rd_bit%0d: got %0b, required %0b", i, s, e);
                else passes++;
            end
        end
        clock_bit(mack, s);
        if (mack) begin
            checks++;
            if (s !== 1'b1) $display("FAIL rd_ack_release: got sda=%0b, required 1", s);
            else passes++;
        end
        $display("read byte %02h master_ack=%0b", got, ~mack);
    endtask

    task automatic test_reset();
        wait_clk(5);
        checks++; if (i2c_sda_o !== 1'b1) $display("FAIL rst_sda: got %0b, required 1", i2c_sda_o); else passes++;
        checks++; if (rd_req !== 1'b0) $display("FAIL rst_rd_req: got %0b, required 0", rd_req); else passes++;
        checks++; if (wr_data !== 8'h00) $display("FAIL rst_wr_data: got %02h, required 00", wr_data); else passes++;
        checks++; if (wr_valid !== 1'b0) $display("FAIL rst_wr_valid: got %0b, required 0", wr_valid); else passes++;
        checks++; if (addr_match !== 1'b0) $display("FAIL rst_addr_match: got %0b, required 0", addr_match); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b, required 0", busy); else passes++;
        reset = 1'b1;
        wait_clk(10);
        checks++; if ({i2c_sda_o, busy, addr_match} !== 3'b100) $display("FAIL post_rst_idle: got %03b, required 100", {i2c_sda_o, busy, addr_match}); else passes++;
        $display("reset released");
    endtask

    task automatic test_write();
        logic ack;
        int w0;
        w0 = wr_cnt;
        i2c_start();
        checks++; if (busy !== 1'b1) $display("FAIL wr_busy: got %0b, required 1", busy); else passes++;
        write_byte(8'hAA, ack);
        checks++; if (ack !== 1'b0) $display("FAIL wr_addr_ack: got %0b, required 0", ack); else passes++;
        checks++; if (addr_match !== 1'b1) $display("FAIL wr_addr_match: got %0b, required 1", addr_match); else passes++;
        exp_wr.push_back(8'hAA);
        write_byte(8'hAA, ack);
        checks++; if (ack !== 1'b0) $display("FAIL wr_data_ack: got %0b, required 0", ack); else passes++;
        i2c_stop();
        checks++; if (busy !== 1'b0) $display("FAIL wr_busy_stop: got %0b, required 0", busy); else passes++;
        checks++; if (addr_match !== 1'b0) $display("FAIL wr_match_stop: got %0b, required 0", addr_match); else passes++;
        checks++; if (wr_data !== 8'hAA) $display("FAIL wr_data_hold: got %02h, required AA", wr_data); else passes++;
        checks++; if (wr_cnt - w0 !== 1) $display("FAIL wr_pulses: got %0d, required 1", wr_cnt - w0); else passes++;
        checks++; if (exp_wr.size() !== 0) $display("FAIL wr_missing: got %0d pending, required 0", exp_wr.size()); else passes++;
    endtask

    task automatic test_bad_addr();
        logic ack;
        int w0;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'h46, ack);
        checks++; if (ack !== 1'b1) $display("FAIL bad_addr_ack: got %0b, required 1", ack); else passes++;
        checks++; if (addr_match !== 1'b0) $display("FAIL bad_addr_match: got %0b, required 0", addr_match); else passes++;
        write_byte(8'h00, ack);
        checks++; if (ack !== 1'b1) $display("FAIL bad_wait_stop_ack: got %0b, required 1", ack); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL bad_busy: got %0b, required 1", busy); else passes++;
        i2c_stop();
        checks++; if (busy !== 1'b0) $display("FAIL bad_busy_stop: got %0b, required 0", busy); else passes++;
        checks++; if (wr_cnt - w0 !== 0) $display("FAIL bad_wr_pulses: got %0d, required 0", wr_cnt - w0); else passes++;
    endtask

    task automatic test_read_nack();
        logic ack;
        int r0;
        r0 = rd_cnt;
        rd_src.push_back(8'h01);
        push_bits(8'h01);
        i2c_start();
        write_byte(8'hAB, ack);
        checks++; if (ack !== 1'b0) $display("FAIL rd1_addr_ack: got %0b, required 0", ack); else passes++;
        checks++; if (rd_cnt - r0 !== 1) $display("FAIL rd1_req_addr: got %0d, required 1", rd_cnt - r0); else passes++;
        read_byte(1'b1);
        checks++; if (addr_match !== 1'b0) $display("FAIL rd1_match_nack: got %0b, required 0", addr_match); else passes++;
        write_byte(8'h00, ack);
        checks++; if (ack !== 1'b1) $display("FAIL rd1_wait_stop: got %0b, required 1", ack); else passes++;
        i2c_stop();
        checks++; if (rd_cnt - r0 !== 1) $display("FAIL rd1_req_total: got %0d, required 1", rd_cnt - r0); else passes++;
    endtask

    task automatic test_back_to_back_read();
        logic ack;
        int r0;
        r0 = rd_cnt;
        rd_src.push_back(8'hC3);
        rd_src.push_back(8'h5A);
        push_bits(8'hC3);
        push_bits(8'h5A);
        i2c_start();
        write_byte(8'hAB, ack);
        checks++; if (ack !== 1'b0) $display("FAIL rd2_addr_ack: got %0b, required 0", ack); else passes++;
        read_byte(1'b0);
        checks++; if (addr_match !== 1'b1) $display("FAIL rd2_match_mid: got %0b, required 1", addr_match); else passes++;
        read_byte(1'b1);
        i2c_stop();
        checks++; if (rd_cnt - r0 !== 2) $display("FAIL rd2_req_total: got %0d, required 2", rd_cnt - r0); else passes++;
    endtask

    task automatic test_repeated_start();
        logic ack;
        logic s;
        int w0;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'hAA, ack);
        checks++; if (ack !== 1'b0) $display("FAIL rs_w_ack: got %0b, required 0", ack); else passes++;
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        rd_src.push_back(8'h7E);
        push_bits(8'h7E);
        i2c_start();
        write_byte(8'hAB, ack);
        checks++; if (ack !== 1'b0) $display("FAIL rs_r_ack: got %0b, required 0", ack); else passes++;
        read_byte(1'b1);
        i2c_stop();
        checks++; if (wr_cnt - w0 !== 0) $display("FAIL rs_partial_write: got %0d pulses, required 0", wr_cnt - w0); else passes++;
    endtask

    task automatic test_reset_mid_ack();
        logic ack;
        logic s;
        logic [7:0] a;
        a = 8'hAA;
        i2c_start();
        for (int i = 7; i >= 0; i--) clock_bit(a[i], s);
        m_sda = 1'b1;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q / 2);
        checks++; if (i2c_sda_o !== 1'b0) $display("FAIL mid_ack_driven: got %0b, required 0", i2c_sda_o); else passes++;
        #1 reset = 1'b0;
        #1;
        checks++; if (i2c_sda_o !== 1'b1) $display("FAIL async_release: got %0b, required 1", i2c_sda_o); else passes++;
        checks++; if ({busy, addr_match, rd_req, wr_valid} !== 4'b0000) $display("FAIL async_outputs: got %04b, required 0000", {busy, addr_match, rd_req, wr_valid}); else passes++;
        checks++; if (wr_data !== 8'h00) $display("FAIL async_wr_data: got %02h, required 00", wr_data); else passes++;
        $display("reset asserted during ACK");
        wait_clk(3);
        reset = 1'b1;
        wait_clk(4);
        m_scl = 1'b0;
        wait_clk(4);
        i2c_stop();
        exp_wr.push_back(8'h3C);
        i2c_start();
        write_byte(8'hAA, ack);
        checks++; if (ack !== 1'b0) $display("FAIL post_rst_addr_ack: got %0b, required 0", ack); else passes++;
        write_byte(8'h3C, ack);
        checks++; if (ack !== 1'b0) $display("FAIL post_rst_data_ack: got %0b, required 0", ack); else passes++;
        i2c_stop();
        checks++; if (exp_wr.size() !== 0) $display("FAIL post_rst_wr_missing: got %0d pending, required 0", exp_wr.size()); else passes++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_bad_addr();
        test_read_nack();
        test_back_to_back_read();
        test_repeated_start();
        test_reset_mid_ack();
        checks++; if (exp_bit.size() !== 0) $display("FAIL rd_bits_left: got %0d, required 0", exp_bit.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
